// File: rtl/mrh_core_if.sv
// Instruction-memory fetch bus between mrh_core (master) and a ROM/RAM (slave).
// Latency: ack may arrive any number of cycles after req; rdata is valid with ack.
// Backpressure: memory stalls fetch by withholding ack; ack is ignored while req=0.
//
// Signals: imem_req/imem_addr driven by the core, imem_rdata/imem_ack by memory.
interface mrh_core_if #(
    parameter int AW = 8
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_rdata;
    logic          imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/mrh_core.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC/UPDATE, NREG x DW register file, ALU with zf/cf.
// Latency: 4 cycles per instruction with zero-wait ack, +1 cycle per fetch wait cycle.
// Backpressure: fetch holds with imem_req high until imem_ack; no other stall points.
//
// Ports: clk/clr (sync active-high reset), imem (fetch bus master), run/step (single-step
// control, used only with MRH_CORE_STEP_EN defined), ip/ir/stage/zf/cf/halt/err status,
// dbg_sel/dbg_data combinational register peek.
// Optional: `define MRH_CORE_STEP_EN to make fetch wait for run/step.
module mrh_core #(
    parameter int DW   = 8,
    parameter int AW   = 8,
    parameter int NREG = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    mrh_core_if.master               imem,
    input  logic                     run,
    input  logic                     step,
    output logic [AW-1:0]            ip,
    output logic [15:0]              ir,
    output logic [3:0]               stage,
    output logic                     zf,
    output logic                     cf,
    output logic                     halt,
    output logic                     err,
    input  logic [$clog2(NREG)-1:0]  dbg_sel,
    output logic [DW-1:0]            dbg_data
);

    localparam int RW = $clog2(NREG);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_UPDATE,
        S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ip_q, ip_d;
    logic [15:0]   ir_q, ir_d;
    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic          zf_q, zf_d;
    logic          cf_q, cf_d;
    logic          halt_q, halt_d;
    logic          err_q, err_d;

    logic          fetch_req;
    logic          fetch_go;
    logic          fetch_hs;

    logic [3:0]    op;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] imm_dw;
    logic [AW-1:0] jmp_tgt;
    logic [DW:0]   sum_w;
    logic [DW:0]   diff_w;
    logic          illegal;
    logic          jmp_taken;

    // Instruction field decode; register indices use only the low RW bits.
    assign op      = ir_q[15:12];
    assign rd      = ir_q[8 +: RW];
    assign rs      = ir_q[4 +: RW];
    assign imm_dw  = DW'(ir_q[7:0]);
    assign jmp_tgt = AW'(ir_q[7:0]);
    assign op_a    = regs_q[rd];
    assign op_b    = regs_q[rs];
    assign sum_w   = {1'b0, op_a} + {1'b0, op_b};
    // The extra top bit of the widened difference is the unsigned borrow.
    assign diff_w  = {1'b0, op_a} - {1'b0, op_b};
    assign illegal = (op >= 4'hB) && (op <= 4'hE);
    assign jmp_taken = (op == 4'h8) || ((op == 4'h9) && zf_q) || ((op == 4'hA) && cf_q);

`ifdef MRH_CORE_STEP_EN
    // go_q gates the fetch request: cleared on each FETCH entry unless run is high,
    // set again once run or step is sampled while idling in FETCH.
    logic go_q, go_d;

    always_comb begin
        go_d = go_q;
        if (state_q == S_FETCH && !go_q && (run || step)) begin
            go_d = 1'b1;
        end else if (state_q == S_UPDATE) begin
            go_d = run;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            go_q <= run;
        end else begin
            go_q <= go_d;
        end
    end

    assign fetch_go = go_q;
`else
    logic unused_step_ctl;
    assign unused_step_ctl = run ^ step;
    assign fetch_go        = 1'b1;
`endif

    // Request is masked during the reset cycle so memory never sees a stale fetch.
    assign imem.imem_req  = fetch_req & ~clr;
    assign imem.imem_addr = ip_q;
    assign fetch_hs       = imem.imem_req & imem.imem_ack;

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (fetch_hs) state_d = S_DECODE;
            S_DECODE: state_d = (op == 4'hF || illegal) ? S_HALT : S_EXEC;
            S_EXEC:   state_d = S_UPDATE;
            S_UPDATE: state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        stage     = 4'b0000;
        fetch_req = 1'b0;
        case (state_q)
            S_FETCH: begin
                stage     = 4'b1000;
                fetch_req = fetch_go;
            end
            S_DECODE: stage = 4'b0100;
            S_EXEC:   stage = 4'b0010;
            S_UPDATE: stage = 4'b0001;
            default:  stage = 4'b0000;
        endcase
    end

    // Datapath next-state.
    always_comb begin
        ip_d   = ip_q;
        ir_d   = ir_q;
        zf_d   = zf_q;
        cf_d   = cf_q;
        halt_d = halt_q;
        err_d  = err_q;
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end

        case (state_q)
            S_FETCH: begin
                if (fetch_hs) ir_d = imem.imem_rdata;
            end
            S_DECODE: begin
                if (op == 4'hF || illegal) halt_d = 1'b1;
                if (illegal)               err_d  = 1'b1;
            end
            S_EXEC: begin
                case (op)
                    4'h1: regs_d[rd] = imm_dw;
                    4'h2: begin
                        regs_d[rd] = sum_w[DW-1:0];
                        cf_d       = sum_w[DW];
                        zf_d       = (sum_w[DW-1:0] == '0);
                    end
                    4'h3: begin
                        regs_d[rd] = diff_w[DW-1:0];
                        cf_d       = diff_w[DW];
                        zf_d       = (diff_w[DW-1:0] == '0);
                    end
                    4'h4: begin
                        regs_d[rd] = op_a & op_b;
                        zf_d       = ((op_a & op_b) == '0);
                    end
                    4'h5: begin
                        regs_d[rd] = op_a | op_b;
                        zf_d       = ((op_a | op_b) == '0);
                    end
                    4'h6: begin
                        regs_d[rd] = op_a ^ op_b;
                        zf_d       = ((op_a ^ op_b) == '0);
                    end
                    4'h7:    regs_d[rd] = op_b;
                    default: ;
                endcase
            end
            S_UPDATE: begin
                ip_d = jmp_taken ? jmp_tgt : (ip_q + AW'(1));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ip_q   <= '0;
            ir_q   <= '0;
            zf_q   <= 1'b0;
            cf_q   <= 1'b0;
            halt_q <= 1'b0;
            err_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            ip_q   <= ip_d;
            ir_q   <= ir_d;
            zf_q   <= zf_d;
            cf_q   <= cf_d;
            halt_q <= halt_d;
            err_q  <= err_d;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign ip       = ip_q;
    assign ir       = ir_q;
    assign zf       = zf_q;
    assign cf       = cf_q;
    assign halt     = halt_q;
    assign err      = err_q;
    assign dbg_data = regs_q[dbg_sel];

endmodule
